button_toggle_gen: RTL and testbench
====================================

BUTTON_TOGGLE_GEN -- requirements
Module: button_toggle_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on btn_in (legal range 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a level change (legal range 2..1024).
REQ-003 Parameter REPEAT_CYCLES, default 16, auto-repeat pulse period in clocks (legal range 2..65535; used only when AUTO_REPEAT_EN is defined).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_in  input  1  raw asynchronous, bouncing push-button level.
REQ-007 t  output  1  registered one-cycle toggle-enable pulse; drives the T input of the downstream toggle flip-flop stage.
REQ-008 btn_level  output  1  registered debounced button level.
REQ-009 busy  output  1  high while in WAIT_PRESS or WAIT_RELEASE.

Function
REQ-010 btn_in SHALL pass through a SYNC_STAGES-deep flop chain; s denotes the last stage.
REQ-011 FSM states: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE; counter cnt sized for DEBOUNCE_CYCLES-1.
REQ-012 IDLE: s=1 -> WAIT_PRESS with cnt=0; else stay.
REQ-013 WAIT_PRESS: s=0 -> IDLE, no pulse; s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, t=1 for exactly one cycle, btn_level=1.
REQ-014 PRESSED: s=0 -> WAIT_RELEASE with cnt=0; else stay.
REQ-015 WAIT_RELEASE: s=1 -> PRESSED with no pulse; s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE with btn_level=0; else cnt+1.
REQ-016 Press latency: with btn_in held high from edge 1, t SHALL be high after edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (7 with defaults) and low after the next edge.
REQ-017 Release latency: btn_level SHALL fall SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after btn_in is first sampled low; release SHALL never produce t.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no t pulse and no btn_level change.
REQ-019 t SHALL be low in every cycle not explicitly defined here as a pulse cycle; two t pulses SHALL never occur on adjacent cycles.

Reset
REQ-020 While reset=1: state=IDLE, cnt=0, repeat counter=0, all synchronizer flops=0, t=0, btn_level=0, busy=0.
REQ-021 Reset asserted mid-debounce or while PRESSED SHALL abort without a pulse.
REQ-022 After reset deasserts with btn_in held high, a full press sequence with latency per REQ-016 SHALL follow.

Configuration
REQ-023 Macro AUTO_REPEAT_EN: when defined, in PRESSED with s=1 a repeat counter SHALL issue a t pulse every REPEAT_CYCLES clocks, the first one REPEAT_CYCLES clocks after the press pulse.
REQ-024 The repeat counter SHALL clear on every entry to PRESSED, including re-entry from WAIT_RELEASE.
REQ-025 When AUTO_REPEAT_EN is undefined, the repeat logic SHALL be absent, REPEAT_CYCLES SHALL be ignored, and only one t pulse SHALL occur per accepted press.

Structure
REQ-026 Package toggle_pkg SHALL hold the FSM state enum typedef and default constants for SYNC_STAGES, DEBOUNCE_CYCLES and REPEAT_CYCLES.
REQ-027 Sub-module btn_sync (parameterized synchronizer chain with synchronous reset) SHALL implement REQ-010; the FSM and counters SHALL live in button_toggle_gen.

Verification
REQ-028 Defaults, reset 2 cycles, then btn_in=1 held -> t=1 in exactly cycle 7 only; btn_level=1 from cycle 7; busy high in cycles 3-6.
REQ-029 Bounce btn_in 1,0,1,0 every 2 cycles, then stable 1 -> no t during bounce; exactly one t once stable for 4 synchronized samples.
REQ-030 Release with 3-cycle glitch high during WAIT_RELEASE -> return to PRESSED, no t; btn_level stays 1 until a clean 4-sample low.
REQ-031 Reset asserted at cnt=2 in WAIT_PRESS -> t never pulses, all outputs 0 next cycle; re-press after reset follows REQ-016.
REQ-032 AUTO_REPEAT_EN defined, REPEAT_CYCLES=16, hold 60 cycles after press pulse -> repeat pulses at +16, +32, +48; none after release.
REQ-033 Pulse t into toggle flip-flop stage, 3 clean presses -> q toggles 0->1->0->1.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and default constants for the debounced button toggle generator.
// FSM state encoding plus the parameter defaults used by button_toggle_gen.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int REPEAT_CYCLES_DEF   = 16;

    // Both debounce-wait states count as busy.
    function automatic logic is_busy(btn_state_e st);
        return (st == WAIT_PRESS) || (st == WAIT_RELEASE);
    endfunction

endpackage

// File: rtl/button_toggle_gen_sync.sv
// btn_sync: STAGES-deep synchronizer chain for the raw button level.
// Synchronous active-high reset clears every flop in the chain.
module btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/button_toggle_gen.sv
// Debounced push-button to one-cycle toggle-enable pulse generator.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module button_toggle_gen
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic t,
    output logic btn_level,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1024) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES out of range 2..1024");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_rep
        $error("REPEAT_CYCLES out of range 2..65535");
    end

    logic s;

    btn_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (s)
    );

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_q, t_d;
    logic             level_q, level_d;

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = 1'b0;
        level_d = level_q;
`ifdef AUTO_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    t_d     = 1'b1;
                    level_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (rep_q == REP_MAX) begin
                    t_d   = 1'b1;
                    rep_d = '0;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
`endif
            end
            WAIT_RELEASE: begin
                // A high sample here is a release glitch: back to PRESSED silently.
                if (s) begin
                    state_d = PRESSED;
`ifdef AUTO_REPEAT_EN
                    rep_d   = '0;
`endif
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            t_q     <= 1'b0;
            level_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            level_q <= level_d;
`ifdef AUTO_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign t         = t_q;
    assign btn_level = level_q;
    assign busy      = is_busy(state_q);

endmodule

// File: tb/tb_button_toggle_gen.sv
// Self-checking bench for button_toggle_gen: directed scenarios plus random
// button activity, compared every cycle against a run-length reference model.
module tb_button_toggle_gen;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int RC = 16;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic t;
    logic btn_level;
    logic busy;

    always #5 clk = ~clk;

    button_toggle_gen #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .t         (t),
        .btn_level (btn_level),
        .busy      (busy)
    );

    // Downstream toggle flip-flop fed by the DUT pulse.
    logic tff_q;
    always @(posedge clk) begin
        if (reset) tff_q <= 1'b0;
        else if (t) tff_q <= ~tff_q;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: level accepted after DC+1 consecutive differing samples.
    bit sq[$];
    bit m_level;
    int m_streak;
    int m_rep;
    bit m_t;
    bit m_tff;
    bit prev_t;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit b);
        bit s;
        if (rst) begin
            sq.delete();
            for (int i = 0; i < SS; i++) sq.push_back(1'b0);
            m_level  = 0;
            m_streak = 0;
            m_rep    = 0;
            m_t      = 0;
            m_tff    = 0;
            return;
        end
        m_tff = m_tff ^ m_t;
        m_t   = 0;
        s = sq.pop_front();
        sq.push_back(b);
        if (s != m_level) begin
            m_streak++;
            if (m_streak == DC + 1) begin
                m_level  = s;
                m_streak = 0;
                m_rep    = 0;
                m_t      = s;
            end
        end else begin
            if (m_streak > 0) m_rep = 0;
`ifdef AUTO_REPEAT_EN
            else if (m_level) begin
                m_rep++;
                if (m_rep == RC) begin
                    m_t   = 1;
                    m_rep = 0;
                end
            end
`endif
            m_streak = 0;
        end
    endtask

    task automatic step(input bit b);
        btn_in = b;
        @(posedge clk);
        model_edge(reset, b);
        @(negedge clk);
        chk("t", int'(t), int'(m_t));
        chk("btn_level", int'(btn_level), int'(m_level));
        chk("busy", int'(busy), int'(m_streak > 0));
        chk("tff_q", int'(tff_q), int'(m_tff));
        chk("t_adjacent", int'(t && prev_t), 0);
        prev_t = t;
    endtask

    initial begin
        int first;
        int npulse;
        int len;
        bit lvl;
        bit bounce[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int offs[$];

        reset  = 1'b1;
        btn_in = 1'b0;
        prev_t = 1'b0;
        model_edge(1'b1, 1'b0);
        @(negedge clk);
        step(0);
        step(0);
        reset = 1'b0;

        // Clean press: pulse exactly at edge SS+DC+1.
        first = -1; npulse = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (t) begin npulse++; if (first < 0) first = k; end
        end
        chk("press_latency", first, SS + DC + 1);
        chk("press_pulses", npulse, 1);

        // Clean release: level falls at edge SS+DC+1, no pulse.
        first = -1; npulse = 0;
        for (int k = 1; k <= 10; k++) begin
            step(0);
            if (t) npulse++;
            if (!btn_level && first < 0) first = k;
        end
        chk("release_latency", first, SS + DC + 1);
        chk("release_pulses", npulse, 0);

        // Bouncing press then stable high.
        npulse = 0;
        foreach (bounce[i]) begin
            step(bounce[i]);
            if (t) npulse++;
        end
        chk("bounce_pulses", npulse, 0);
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (t) npulse++;
        end
        chk("stable_after_bounce_pulses", npulse, 1);

        // Release with a 3-cycle high glitch while waiting to release.
        npulse = 0;
        for (int k = 0; k < 3; k++) step(0);
        for (int k = 0; k < 3; k++) begin step(1); if (t) npulse++; end
        chk("glitch_level_held", int'(btn_level), 1);
        chk("glitch_pulses", npulse, 0);
        for (int k = 0; k < 12; k++) begin step(0); if (t) npulse++; end
        chk("glitch_release_level", int'(btn_level), 0);
        chk("glitch_release_pulses", npulse, 0);

        // Reset in the middle of a press debounce.
        for (int k = 0; k < 5; k++) step(1);
        reset = 1'b1;
        step(1);
        chk("abort_t", int'(t), 0);
        chk("abort_level", int'(btn_level), 0);
        chk("abort_busy", int'(busy), 0);
        reset = 1'b0;
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (t && first < 0) first = k;
        end
        chk("repress_latency", first, SS + DC + 1);

        // Three clean presses through the toggle flip-flop.
        reset = 1'b1;
        step(0);
        step(0);
        reset = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 12; k++) step(1);
            chk("tff_after_press", int'(tff_q), (p % 2 == 0) ? 1 : 0);
            for (int k = 0; k < 12; k++) step(0);
        end

`ifdef AUTO_REPEAT_EN
        // Hold after the press pulse and log repeat pulse offsets.
        first = -1;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            step(1);
            if (t) first = k;
        end
        chk("repeat_press_seen", int'(first > 0), 1);
        for (int k = 1; k <= 60; k++) begin
            step(1);
            if (t) offs.push_back(k);
        end
        chk("repeat_count", offs.size(), 3);
        for (int i = 0; i < 3 && i < offs.size(); i++)
            chk("repeat_offset", offs[i], RC * (i + 1));
        npulse = 0;
        for (int k = 0; k < 20; k++) begin step(0); if (t) npulse++; end
        chk("repeat_after_release", npulse, 0);
`endif

        // Random button activity with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * DC + 4);
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                step(lvl);
                reset = 1'b0;
            end
            for (int k = 0; k < len; k++) step(lvl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
